// File: rtl/vec_normalize_if.sv
// Handshake and operand bundle for vec_normalize: input vector, inverse-sqrt side
// channel and output vector. The slave modport is the normalizer's view.
interface vec_normalize_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_x;
    logic [23:0] in_y;
    logic [23:0] in_z;
    logic [23:0] isq_x;
    logic [23:0] isq_y;
    logic [23:0] isq_z;
    logic [24:0] isq_out;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_x;
    logic [23:0] out_y;
    logic [23:0] out_z;

    modport slave (
        input  in_valid, in_x, in_y, in_z, isq_out, out_ready,
        output in_ready, isq_x, isq_y, isq_z, out_valid, out_x, out_y, out_z
    );

    modport master (
        output in_valid, in_x, in_y, in_z, isq_out, out_ready,
        input  in_ready, isq_x, isq_y, isq_z, out_valid, out_x, out_y, out_z
    );
endinterface

// File: rtl/vec_normalize.sv
// Vector normalizer: scales a signed 24-bit vector by an external inverse-sqrt result.
// Define VEC_NORM_SAT_EN to saturate the scaled components instead of wrapping them.
module vec_normalize #(
    parameter int unsigned INV_LAT    = 11,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    vec_normalize_if.slave bus
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + INV_LAT + 2) + 1;

    logic               run;
    logic               accept;
    logic               push;
    logic               pop;
    logic [INV_LAT-1:0] dl_valid;
    logic [23:0]        dl_x [INV_LAT];
    logic [23:0]        dl_y [INV_LAT];
    logic [23:0]        dl_z [INV_LAT];
    logic               prod_valid;
    logic [23:0]        prod_x;
    logic [23:0]        prod_y;
    logic [23:0]        prod_z;
    logic [23:0]        mem_x [FIFO_DEPTH];
    logic [23:0]        mem_y [FIFO_DEPTH];
    logic [23:0]        mem_z [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      inflight;

    function automatic logic [23:0] scale(input logic [23:0] comp, input logic [24:0] isq);
        logic signed [49:0] prod;
        logic signed [49:0] rnd;
`ifdef VEC_NORM_SAT_EN
        logic signed [25:0] res;
`endif
        prod = $signed(comp) * $signed({1'b0, isq});
        rnd  = prod + (50'sd1 <<< 23);
`ifdef VEC_NORM_SAT_EN
        res = 26'(rnd >>> 24);
        if (res > 26'sd8388607) begin
            return 24'h7FFFFF;
        end else if (res < -26'sd8388608) begin
            return 24'h800000;
        end
        return res[23:0];
`else
        return 24'(rnd >>> 24);
`endif
    endfunction

    assign bus.isq_x = bus.in_x;
    assign bus.isq_y = bus.in_y;
    assign bus.isq_z = bus.in_z;

    // Credits cover every vector that will eventually land in the FIFO.
    always_comb begin
        inflight = CW'(prod_valid);
        for (int unsigned i = 0; i < INV_LAT; i++) begin
            inflight = inflight + CW'(dl_valid[i]);
        end
    end

    assign bus.in_ready  = run && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (fifo_count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = prod_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            dl_valid   <= '0;
            prod_valid <= 1'b0;
        end else begin
            run         <= 1'b1;
            dl_valid[0] <= accept;
            for (int unsigned i = 1; i < INV_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
            prod_valid <= dl_valid[INV_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        dl_x[0] <= bus.in_x;
        dl_y[0] <= bus.in_y;
        dl_z[0] <= bus.in_z;
        for (int unsigned i = 1; i < INV_LAT; i++) begin
            dl_x[i] <= dl_x[i-1];
            dl_y[i] <= dl_y[i-1];
            dl_z[i] <= dl_z[i-1];
        end
        prod_x <= scale(dl_x[INV_LAT-1], bus.isq_out);
        prod_y <= scale(dl_y[INV_LAT-1], bus.isq_out);
        prod_z <= scale(dl_z[INV_LAT-1], bus.isq_out);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_x[i] <= '0;
                mem_y[i] <= '0;
                mem_z[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_x[wr_ptr] <= prod_x;
                mem_y[wr_ptr] <= prod_y;
                mem_z[wr_ptr] <= prod_z;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.out_x = mem_x[rd_ptr];
    assign bus.out_y = mem_y[rd_ptr];
    assign bus.out_z = mem_z[rd_ptr];
endmodule

// File: tb/tb_vec_normalize.sv
// Self-checking bench for vec_normalize: plays the inverse-sqrt unit with a fixed
// latency and scores outputs against an arithmetic model of the normalization.
module tb_vec_normalize;
    localparam int unsigned INV_LAT    = 11;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct packed {
        logic [23:0] x;
        logic [23:0] y;
        logic [23:0] z;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vec_normalize_if bus ();

    vec_normalize #(
        .INV_LAT   (INV_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    vec_t        exp_q[$];
    logic [24:0] sched[64];
    logic [24:0] next_isq;
    int          cyc = 0;
    int          passed = 0;
    int          fails = 0;
    int          total = 0;
    int          accepts = 0;
    int          pops = 0;
    logic        s_out_valid;
    logic        s_in_ready;
    vec_t        s_pop;
    logic        hold_pending = 1'b0;
    vec_t        hold_val;

    function automatic logic [23:0] norm(input logic [23:0] c, input logic [24:0] s);
        longint p;
        longint r;
        logic [63:0] u;
        p = longint'($signed(c)) * longint'(s);
        r = (p + 64'sd8388608) >>> 24;
`ifdef VEC_NORM_SAT_EN
        if (r > 64'sd8388607) r = 64'sd8388607;
        else if (r < -64'sd8388608) r = -64'sd8388608;
`endif
        u = r;
        return u[23:0];
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [23:0] x, input logic [23:0] y,
                         input logic [23:0] z, input logic [24:0] isq);
        bus.in_valid = v;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_z     = z;
        next_isq     = isq;
    endtask

    task automatic drive_random(input logic v);
        drive(v, 24'($urandom), 24'($urandom), 24'($urandom), 25'($urandom));
    endtask

    // One clock: observe at the falling edge, then advance and present isq_out.
    task automatic tick();
        vec_t cur;
        vec_t e;
        @(negedge clk);
        cur = '{bus.out_x, bus.out_y, bus.out_z};
        if (hold_pending && bus.out_valid) check("hold_stable", 72'(cur), 72'(hold_val));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 72'(bus.out_valid), 72'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_data", 72'(cur), 72'(e));
            end
            s_pop = cur;
            pops++;
        end
        hold_pending = bus.out_valid && !bus.out_ready;
        hold_val     = cur;
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back('{norm(bus.in_x, next_isq), norm(bus.in_y, next_isq),
                              norm(bus.in_z, next_isq)});
            sched[(cyc + INV_LAT) % 64] = next_isq;
            accepts++;
        end
        s_out_valid = bus.out_valid;
        s_in_ready  = bus.in_ready;
        @(posedge clk);
        cyc++;
        #1;
        bus.isq_out          = sched[cyc % 64];
        sched[cyc % 64]      = 25'($urandom);
    endtask

    task automatic send_and_wait(input logic [23:0] x, input logic [23:0] y,
                                 input logic [23:0] z, input logic [24:0] isq,
                                 output int lat);
        int c0;
        int p0;
        int a0;
        lat = -1;
        a0 = accepts;
        p0 = pops;
        drive(1'b1, x, y, z, isq);
        c0 = cyc;
        tick();
        check("accepted", 72'(accepts - a0), 72'(1));
        drive(1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 40; k++) begin
            int c;
            c = cyc;
            tick();
            if (pops != p0) begin
                lat = c - c0;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int a0;
        int p0;
        int seen;
        for (int i = 0; i < 64; i++) sched[i] = 25'($urandom);
        drive(1'b0, '0, '0, '0, '0);
        bus.out_ready = 1'b1;
        bus.isq_out   = '0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 72'(s_in_ready), 72'(0));
        check("rst_out_valid", 72'(s_out_valid), 72'(0));
        check("rst_out_xyz", 72'({bus.out_x, bus.out_y, bus.out_z}), 72'(0));
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 72'(bus.in_ready), 72'(1));

        // Unit scale, with exact latency
        send_and_wait(24'h001000, 24'h000000, 24'h000000, 25'h1000000, lat);
        check("latency", 72'(lat), 72'(INV_LAT + 2));
        check("unit_scale", 72'(s_pop), 72'({24'h001000, 24'h000000, 24'h000000}));

        // Half scale with negative component
        send_and_wait(24'hFFF800, 24'h000800, 24'h000000, 25'h0800000, lat);
        check("half_scale", 72'(s_pop), 72'({24'hFFFC00, 24'h000400, 24'h000000}));

        // Zero vector ignores isq_out
        send_and_wait(24'h000000, 24'h000000, 24'h000000, 25'h1FFFFFF, lat);
        check("zero_vec", 72'(s_pop), 72'(0));

        // Overflow: saturate or wrap
        send_and_wait(24'h7FFFFF, 24'h800000, 24'h000000, 25'h1FFFFFF, lat);
`ifdef VEC_NORM_SAT_EN
        check("overflow", 72'(s_pop), 72'({24'h7FFFFF, 24'h800000, 24'h000000}));
`else
        check("overflow", 72'(s_pop), 72'({24'hFFFFFE, 24'h000001, 24'h000000}));
`endif

        // Output stalled with continuous input: credits fill the FIFO exactly
        bus.out_ready = 1'b0;
        a0 = accepts;
        for (int k = 0; k < 30; k++) begin
            drive_random(1'b1);
            tick();
        end
        check("stall_accepts", 72'(accepts - a0), 72'(FIFO_DEPTH));
        check("stall_in_ready", 72'(s_in_ready), 72'(0));
        check("stall_out_valid", 72'(s_out_valid), 72'(1));
        drive(1'b0, '0, '0, '0, '0);
        bus.out_ready = 1'b1;
        p0 = pops;
        for (int k = 0; k < 20; k++) tick();
        check("stall_drain", 72'(pops - p0), 72'(FIFO_DEPTH));

        // Toggling out_ready at full input rate
        for (int k = 0; k < 200; k++) begin
            drive_random(1'b1);
            bus.out_ready = k[0];
            tick();
        end

        // Random valid / ready
        for (int k = 0; k < 300; k++) begin
            drive_random(($urandom % 4) != 0);
            bus.out_ready = ($urandom % 3) != 0;
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        check("all_drained", 72'(pops), 72'(accepts));

        // Reset with three vectors in flight
        a0 = accepts;
        for (int k = 0; k < 3; k++) begin
            drive_random(1'b1);
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        check("flight_accepts", 72'(accepts - a0), 72'(3));
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
        tick();
        tick();
        check("midrst_in_ready", 72'(s_in_ready), 72'(0));
        check("midrst_out_valid", 72'(s_out_valid), 72'(0));
        rst_n = 1'b1;
        seen = 0;
        tick();
        if (s_out_valid) seen++;
        check("ready_after_midrst", 72'(bus.in_ready), 72'(1));
        for (int k = 0; k < INV_LAT + 2; k++) begin
            tick();
            if (s_out_valid) seen++;
        end
        check("no_ghost_out", 72'(seen), 72'(0));

        // Traffic after mid-run reset still scores correctly
        send_and_wait(24'h000123, 24'hFFFEDD, 24'h400000, 25'h0C00000, lat);
        check("post_rst_latency", 72'(lat), 72'(INV_LAT + 2));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
